// File: rtl/ma_result_collector.sv
// rtl/ma_result_collector.sv - multiply-adder tree result collector: tag delay, accumulate, quantise, output FIFO, issue credit.
// Optional RELU_EN clamps negative quantised results to zero.
module ma_result_collector #(
   parameter int PIPE_LATENCY = 5,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        issue_valid,
   input  logic        issue_last,
   output logic        issue_ready,
   input  logic [31:0] ma_out,
   input  logic [31:0] bias,
   input  logic [4:0]  shift,
   output logic [7:0]  out_data,
   output logic        out_valid,
   input  logic        out_ready,
   output logic        overflow
);

   localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CW = AW + 1;
   localparam int LW = $clog2(PIPE_LATENCY + FIFO_DEPTH + 1);

   logic [PIPE_LATENCY-1:0] tag_valid_q, tag_valid_d;
   logic [PIPE_LATENCY-1:0] tag_last_q, tag_last_d;
   logic [31:0]             acc_q, acc_d;
   logic [7:0]              mem_q [FIFO_DEPTH];
   logic [7:0]              mem_d [FIFO_DEPTH];
   logic [AW-1:0]           wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]           rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]           count_q, count_d;
   logic                    overflow_q, overflow_d;

   logic                    tag_v, tag_l;
   logic [LW-1:0]           inflight_last;
   logic [LW-1:0]           credit_sum;
   logic [31:0]             sum;
   logic signed [32:0]      sum_ext;
   logic signed [32:0]      round_add;
   logic signed [32:0]      rounded;
   logic signed [32:0]      shifted;
   logic [7:0]              quant;
   logic                    push_req, push, pop;

   assign tag_v = tag_valid_q[PIPE_LATENCY-1];
   assign tag_l = tag_last_q[PIPE_LATENCY-1];

   // Credit counts every last tag still travelling, including the one consumed this cycle.
   always_comb begin
      inflight_last = '0;
      for (int i = 0; i < PIPE_LATENCY; i++) begin
         inflight_last = inflight_last + LW'(tag_last_q[i]);
      end
      credit_sum  = LW'(count_q) + inflight_last;
      issue_ready = credit_sum < LW'(FIFO_DEPTH);
   end

   always_comb begin
      sum       = acc_q + ma_out + bias;
      sum_ext   = $signed({sum[31], sum});
      round_add = (shift == 5'd0) ? 33'sd0 : (33'sd1 <<< (shift - 5'd1));
      rounded   = sum_ext + round_add;
      shifted   = rounded >>> shift;
      if (shifted > 33'sd127) begin
         quant = 8'h7f;
      end else if (shifted < -33'sd128) begin
         quant = 8'h80;
      end else begin
         quant = shifted[7:0];
      end
`ifdef RELU_EN
      if (quant[7]) begin
         quant = 8'h00;
      end
`endif
   end

   assign out_valid = (count_q != '0);
   assign out_data  = out_valid ? mem_q[rd_ptr_q] : 8'h00;
   assign overflow  = overflow_q;

   // A push into a full FIFO is only taken when the head leaves in the same cycle.
   assign push_req = tag_v & tag_l;
   assign pop      = out_valid & out_ready;
   assign push     = push_req & ((count_q < CW'(FIFO_DEPTH)) | pop);

   always_comb begin
      tag_valid_d    = tag_valid_q;
      tag_last_d     = tag_last_q;
      tag_valid_d[0] = issue_valid;
      tag_last_d[0]  = issue_valid & issue_last;
      for (int i = 1; i < PIPE_LATENCY; i++) begin
         tag_valid_d[i] = tag_valid_q[i-1];
         tag_last_d[i]  = tag_last_q[i-1];
      end

      acc_d = acc_q;
      if (tag_v) begin
         acc_d = tag_l ? 32'd0 : (acc_q + ma_out);
      end

      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (push) begin
         mem_d[wr_ptr_q] = quant;
         wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + AW'(1);
      end
      count_d = count_q + CW'(push) - CW'(pop);

      overflow_d = overflow_q | (issue_valid & ~issue_ready);
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         tag_valid_q <= '0;
         tag_last_q  <= '0;
         acc_q       <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         overflow_q  <= 1'b0;
      end else begin
         tag_valid_q <= tag_valid_d;
         tag_last_q  <= tag_last_d;
         acc_q       <= acc_d;
         mem_q       <= mem_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         overflow_q  <= overflow_d;
      end
   end

endmodule

// File: tb/tb_ma_result_collector.sv
// tb/tb_ma_result_collector.sv - directed self-checking bench for ma_result_collector.
module tb_ma_result_collector;

   localparam int PL = 5;
   localparam int DEPTH = 4;
`ifdef RELU_EN
   localparam int EXP_NEG24   = 0;
   localparam int EXP_NEG5000 = 0;
`else
   localparam int EXP_NEG24   = -1;
   localparam int EXP_NEG5000 = -128;
`endif

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        issue_valid = 1'b0;
   logic        issue_last = 1'b0;
   logic        issue_ready;
   logic [31:0] ma_out;
   logic [31:0] bias = '0;
   logic [4:0]  shift = '0;
   logic [7:0]  out_data;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic        overflow;
   logic [31:0] issue_data = '0;
   logic [31:0] tree_q [PL];

   int n_checks = 0;
   int n_fail   = 0;

   ma_result_collector #(.PIPE_LATENCY(PL), .FIFO_DEPTH(DEPTH)) dut (
      .clock(clock), .reset(reset),
      .issue_valid(issue_valid), .issue_last(issue_last), .issue_ready(issue_ready),
      .ma_out(ma_out), .bias(bias), .shift(shift),
      .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
      .overflow(overflow)
   );

   always #5 clock = ~clock;

   // Fixed-latency tree model: the sum for an issue appears PL cycles later.
   always @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < PL; i++) tree_q[i] <= '0;
      end else begin
         tree_q[0] <= issue_valid ? issue_data : 32'd0;
         for (int i = 1; i < PL; i++) tree_q[i] <= tree_q[i-1];
      end
   end
   assign ma_out = tree_q[PL-1];

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, $signed(got), $signed(exp));
      end
   endtask

   function automatic logic [31:0] sx(input logic [7:0] v);
      return {{24{v[7]}}, v};
   endfunction

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic do_issue(input logic [31:0] val, input logic last);
      issue_valid = 1'b1;
      issue_last  = last;
      issue_data  = val;
      step();
      issue_valid = 1'b0;
      issue_last  = 1'b0;
   endtask

   task automatic wait_valid();
      int n = 0;
      while (!out_valid && n < 20) begin
         step();
         n++;
      end
      check_eq("wait_valid", {31'd0, out_valid}, 32'd1);
   endtask

   task automatic run_pixel(input logic [31:0] val, input int exp, input string tag);
      do_issue(val, 1'b1);
      wait_valid();
      check_eq(tag, sx(out_data), exp);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      step();
      step();
      check_eq("rst_out_valid", {31'd0, out_valid}, 32'd0);
      check_eq("rst_out_data", sx(out_data), 32'd0);
      check_eq("rst_overflow", {31'd0, overflow}, 32'd0);
      check_eq("rst_issue_ready", {31'd0, issue_ready}, 32'd1);
      reset = 1'b1;
      step();

      // Single pixel: 20+30-5+10 = 55, visible in cycle 8.
      bias  = 32'd10;
      shift = 5'd0;
      do_issue(32'd20, 1'b0);
      do_issue(32'd30, 1'b0);
      do_issue(-32'sd5, 1'b1);
      for (int k = 3; k < 8; k++) begin
         check_eq("sp_early_valid", {31'd0, out_valid}, 32'd0);
         step();
      end
      check_eq("sp_valid_cycle8", {31'd0, out_valid}, 32'd1);
      check_eq("sp_data", sx(out_data), 32'd55);
      check_eq("sp_acc_cleared", dut.acc_q, 32'd0);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      check_eq("sp_popped", {31'd0, out_valid}, 32'd0);

      // Rounding and saturation.
      bias  = 32'd0;
      shift = 5'd4;
      run_pixel(32'd24, 2, "rnd_pos24");
      run_pixel(-32'sd24, EXP_NEG24, "rnd_neg24");
      run_pixel(32'd5000, 127, "sat_pos");
      run_pixel(-32'sd5000, EXP_NEG5000, "sat_neg");
      shift = 5'd0;

      // Backpressure: credit runs out after four pixels.
      for (int i = 1; i <= 4; i++) begin
         check_eq("bp_ready_before", {31'd0, issue_ready}, 32'd1);
         do_issue(i, 1'b1);
      end
      check_eq("bp_ready_drop", {31'd0, issue_ready}, 32'd0);
      for (int k = 0; k < 7; k++) step();
      check_eq("bp_full_valid", {31'd0, out_valid}, 32'd1);
      check_eq("bp_full_ready", {31'd0, issue_ready}, 32'd0);
      check_eq("bp_overflow", {31'd0, overflow}, 32'd0);
      out_ready = 1'b1;
      for (int j = 1; j <= 4; j++) begin
         check_eq("bp_drain", sx(out_data), j);
         step();
      end
      out_ready = 1'b0;
      check_eq("bp_empty", {31'd0, out_valid}, 32'd0);
      check_eq("bp_ready_back", {31'd0, issue_ready}, 32'd1);
      run_pixel(32'd5, 5, "bp_px5");
      run_pixel(32'd6, 6, "bp_px6");

      // Fill FIFO, then force issues so pushes meet pops at full occupancy.
      for (int i = 0; i < 4; i++) do_issue(32'd11 + i, 1'b1);
      for (int k = 0; k < 7; k++) step();
      check_eq("of_ready_low", {31'd0, issue_ready}, 32'd0);
      check_eq("of_pre_overflow", {31'd0, overflow}, 32'd0);
      for (int i = 0; i < 4; i++) do_issue(32'd21 + i, 1'b1);
      check_eq("of_overflow_set", {31'd0, overflow}, 32'd1);
      step();
      out_ready = 1'b1;
      for (int j = 0; j < 4; j++) begin
         check_eq("full_pp_valid", {31'd0, out_valid}, 32'd1);
         check_eq("full_pp_data", sx(out_data), 32'd11 + j);
         step();
      end
      for (int j = 0; j < 4; j++) begin
         check_eq("full_tail_data", sx(out_data), 32'd21 + j);
         step();
      end
      out_ready = 1'b0;
      check_eq("full_empty", {31'd0, out_valid}, 32'd0);
      for (int k = 0; k < 3; k++) step();
      check_eq("of_sticky", {31'd0, overflow}, 32'd1);

      // Reset mid-pixel discards the FIFO and in-flight partials.
      do_issue(32'd33, 1'b1);
      wait_valid();
      check_eq("rm_pre_data", sx(out_data), 32'd33);
      do_issue(32'd100, 1'b0);
      do_issue(32'd200, 1'b0);
      #2;
      reset = 1'b0;
      #1;
      check_eq("rm_valid_low", {31'd0, out_valid}, 32'd0);
      check_eq("rm_overflow_clr", {31'd0, overflow}, 32'd0);
      check_eq("rm_ready", {31'd0, issue_ready}, 32'd1);
      @(posedge clock);
      #1;
      reset = 1'b1;
      for (int k = 0; k < 8; k++) step();
      check_eq("rm_no_stale", {31'd0, out_valid}, 32'd0);
      run_pixel(32'd7, 7, "rm_new_pixel");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
